// File: rtl/mfp_ahb_master.sv
// Single-outstanding AHB-lite master: command/response handshake -> SINGLE transfers.
// Latency: accept at N, address phase N+1, data phase N+2, rsp_valid N+3 (+1 per HREADY-low cycle).
// Backpressure: cmd_ready only in IDLE; HREADY stalls hold the bus. MFP_AHBM_ALIGN_CHECK_EN rejects misaligned commands locally.
module mfp_ahb_master #(
    parameter logic [3:0] HPROT_VAL  = 4'b0011,
    parameter int         WAIT_CNT_W = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [31:0]           cmd_addr,
    input  logic [1:0]            cmd_size,
    input  logic [31:0]           cmd_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [WAIT_CNT_W-1:0] rsp_waits,
    output logic [31:0]           HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic                  HMASTLOCK,
    output logic [31:0]           HWDATA,
    input  logic [31:0]           HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

    localparam logic [1:0]            TRANS_IDLE   = 2'b00;
    localparam logic [1:0]            TRANS_NONSEQ = 2'b10;
    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX     = '1;
    localparam logic [WAIT_CNT_W-1:0] WAIT_ONE     = {{(WAIT_CNT_W-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic [31:0]           haddr_q, haddr_d;
    logic [1:0]            htrans_q, htrans_d;
    logic                  hwrite_q, hwrite_d;
    logic [1:0]            hsize_q, hsize_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           hwdata_q, hwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic [WAIT_CNT_W-1:0] wait_q, wait_d;

    logic                  accept;
    logic                  launch;
    logic [1:0]            size_n;
    logic [WAIT_CNT_W-1:0] wait_inc;

    function automatic logic [31:0] lane_replicate(input logic [31:0] d, input logic [1:0] sz);
        case (sz)
            2'd0:    return {4{d[7:0]}};
            2'd1:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] d, input logic [1:0] off,
                                                 input logic [1:0] sz);
        logic [31:0] sh;
        sh = d >> {off, 3'b000};
        case (sz)
            2'd0:    return {24'b0, sh[7:0]};
            2'd1:    return off[1] ? {16'b0, d[31:16]} : {16'b0, d[15:0]};
            default: return d;
        endcase
    endfunction

    // Reserved size 3 travels as a word everywhere, including HSIZE.
    assign size_n   = (cmd_size == 2'd3) ? 2'd2 : cmd_size;
    assign accept   = cmd_valid & cmd_ready_q & (state_q == ST_IDLE);
    assign wait_inc = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_ONE;

`ifdef MFP_AHBM_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = ((size_n == 2'd1) && cmd_addr[0]) ||
                        ((size_n == 2'd2) && (cmd_addr[1:0] != 2'b00));
    assign launch     = accept & ~misaligned;
`else
    assign launch     = accept;
`endif

    always_comb begin
        state_d     = state_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        wdata_d     = wdata_q;
        hwdata_d    = hwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        wait_d      = wait_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    wait_d = '0;
                    if (launch) begin
                        state_d  = ST_ADDR;
                        htrans_d = TRANS_NONSEQ;
                        haddr_d  = cmd_addr;
                        hwrite_d = cmd_write;
                        hsize_d  = size_n;
                        wdata_d  = lane_replicate(cmd_wdata, size_n);
                    end else begin
                        // Rejected locally: answer immediately without touching the bus.
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    state_d  = ST_DATA;
                    htrans_d = TRANS_IDLE;
                    hwdata_d = wdata_q;
                end else begin
                    wait_d = wait_inc;
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    state_d     = ST_IDLE;
                    hwdata_d    = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = HRESP;
                    rsp_rdata_d = (HRESP || hwrite_q) ? 32'd0
                                                      : lane_extract(HRDATA, haddr_q[1:0], hsize_q);
                end else begin
                    wait_d = wait_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            haddr_q     <= '0;
            htrans_q    <= TRANS_IDLE;
            hwrite_q    <= 1'b0;
            hsize_q     <= '0;
            wdata_q     <= '0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            wdata_q     <= wdata_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            wait_q      <= wait_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_waits = wait_q;
    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = {1'b0, hsize_q};
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = hwdata_q;
endmodule
